// File: rtl/ppi_port_a_strobed_ctrl_pkg.sv
// ppi_pkg: shared state encodings and direction constants for the PPI port A strobed controller
package ppi_pkg;
    typedef enum logic [1:0] {IN_EMPTY, IN_STROBED, IN_FULL} in_state_t;
    typedef enum logic [1:0] {OUT_EMPTY, OUT_LOADED, OUT_ACKED} out_state_t;
    localparam logic DIR_IN  = 1'b1;
    localparam logic DIR_OUT = 1'b0;
endpackage

// File: rtl/ppi_port_a_strobed_ctrl_edge_sync.sv
// ppi_edge_sync: synchronizes an async active-low strobe and emits one-cycle fall/rise pulses
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous preset of the chain to idle-high
//   din        : async input
//   fall, rise : one-cycle edge pulses, valid SYNC_STAGES-1 edges after first sampling
module ppi_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic din,
    output logic fall,
    output logic rise
);
    logic [STAGES-1:0] sync_q;
    logic              last_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync_q <= '1;
            last_q <= 1'b1;
        end else if (clr) begin
            sync_q <= '1;
            last_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            last_q <= sync_q[STAGES-1];
        end
    assign fall = last_q & ~sync_q[STAGES-1];
    assign rise = ~last_q & sync_q[STAGES-1];
endmodule

// File: rtl/ppi_port_a_strobed_ctrl.sv
// ppi_port_a_strobed_ctrl: mode-1 strobed handshake controller for PPI port A
//   CLK, RESET_bar          : clock, async active-low reset
//   cfg_wr, cfg_dir         : direction load (1 = strobed input), clears handshake state
//   inte_wr, inte_val       : interrupt enable write
//   cpu_rd, cpu_wr          : one-cycle CPU port A access strobes, cpu_wdata write data
//   cpu_rdata               : input latch contents
//   PA_in, PA_out, PA_oe    : port A pins in, output latch, drive enable
//   STB_bar, ACK_bar        : async external strobe / acknowledge
//   IBF, OBF_bar, INTR, INTE, OVR : handshake and status flags
module ppi_port_a_strobed_ctrl
    import ppi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET_bar,
    input  logic             cfg_wr,
    input  logic             cfg_dir,
    input  logic             inte_wr,
    input  logic             inte_val,
    input  logic             cpu_rd,
    input  logic             cpu_wr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic [WIDTH-1:0] PA_in,
    output logic [WIDTH-1:0] PA_out,
    output logic             PA_oe,
    input  logic             STB_bar,
    input  logic             ACK_bar,
    output logic             IBF,
    output logic             OBF_bar,
    output logic             INTR,
    output logic             INTE,
    output logic             OVR
);
    logic             dir;
    in_state_t        in_st;
    out_state_t       out_st;
    logic             rd_early;
    logic [WIDTH-1:0] in_latch;
    logic             stb_fall, stb_rise, ack_fall, ack_rise;
    logic             rd_seen;

    ppi_edge_sync #(.STAGES(SYNC_STAGES)) u_stb_sync (
        .clk(CLK), .rst_n(RESET_bar), .clr(cfg_wr), .din(STB_bar), .fall(stb_fall), .rise(stb_rise)
    );
    ppi_edge_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk(CLK), .rst_n(RESET_bar), .clr(cfg_wr), .din(ACK_bar), .fall(ack_fall), .rise(ack_rise)
    );

    assign cpu_rdata = in_latch;
    assign PA_oe     = ~dir;
    // a read anywhere in the strobe window empties the buffer and suppresses INTR on release
    assign rd_seen   = rd_early | cpu_rd;

    always_ff @(posedge CLK or negedge RESET_bar)
        if (!RESET_bar) begin
            dir      <= DIR_IN;
            in_st    <= IN_EMPTY;
            out_st   <= OUT_EMPTY;
            rd_early <= 1'b0;
            in_latch <= '0;
            PA_out   <= '0;
            IBF      <= 1'b0;
            OBF_bar  <= 1'b1;
            INTR     <= 1'b0;
            INTE     <= 1'b0;
            OVR      <= 1'b0;
        end else if (cfg_wr) begin
            dir      <= cfg_dir;
            in_st    <= IN_EMPTY;
            out_st   <= OUT_EMPTY;
            rd_early <= 1'b0;
            in_latch <= '0;
            PA_out   <= '0;
            IBF      <= 1'b0;
            OBF_bar  <= 1'b1;
            INTR     <= 1'b0;
            INTE     <= 1'b0;
            OVR      <= 1'b0;
        end else begin
            if (cpu_wr)
                PA_out <= cpu_wdata;
            if (dir == DIR_IN) begin
                if (stb_fall) begin
                    // a new strobe always wins, even over a same-cycle read
                    in_latch <= PA_in;
                    IBF      <= 1'b1;
                    OVR      <= OVR | IBF;
                    rd_early <= 1'b0;
                    in_st    <= IN_STROBED;
                end else begin
                    if (cpu_rd && in_st != IN_EMPTY) begin
                        IBF  <= 1'b0;
                        INTR <= 1'b0;
                    end
                    if (in_st == IN_FULL && cpu_rd)
                        in_st <= IN_EMPTY;
                    if (in_st == IN_STROBED) begin
                        if (cpu_rd)
                            rd_early <= 1'b1;
                        if (stb_rise) begin
                            in_st <= rd_seen ? IN_EMPTY : IN_FULL;
                            if (!rd_seen)
                                INTR <= INTE;
                        end
                    end
                end
            end else begin
                // a CPU write discards any coincident acknowledge edge
                if (cpu_wr) begin
                    OBF_bar <= 1'b0;
                    INTR    <= 1'b0;
                    out_st  <= OUT_LOADED;
                end else if (ack_fall && out_st == OUT_LOADED) begin
                    OBF_bar <= 1'b1;
                    out_st  <= OUT_ACKED;
                end else if (ack_rise && out_st == OUT_ACKED) begin
                    INTR    <= INTE;
                    out_st  <= OUT_EMPTY;
                end
            end
            if (inte_wr) begin
                INTE <= inte_val;
                if (!inte_val)
                    INTR <= 1'b0;
            end
        end
endmodule
